// File: rtl/sc_mux_seq_if.sv
// rtl/sc_mux_seq_if.sv - channel/handshake bundle for the slow-control mux sequencer
interface sc_mux_seq_if #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 22,
  parameter int SEL_W  = 5
);
  logic [N_CH*DATA_W-1:0] in_data;
  logic [1:0]             mode;
  logic [SEL_W-1:0]       sel;
  logic                   start;
  logic                   hold;
  logic [DATA_W-1:0]      out_data;
  logic [SEL_W-1:0]       out_ch;
  logic                   out_vld;
  logic                   out_ready;
  logic                   busy;
  logic                   done;
  logic                   err_sel;
  logic                   err_clr;

  modport slave (
    input  in_data, mode, sel, start, hold, out_ready, err_clr,
    output out_data, out_ch, out_vld, busy, done, err_sel
  );

  modport master (
    output in_data, mode, sel, start, hold, out_ready, err_clr,
    input  out_data, out_ch, out_vld, busy, done, err_sel
  );
endinterface

// File: rtl/sc_mux_seq.sv
// rtl/sc_mux_seq.sv - N_CH-to-1 slow-control word mux with manual, single-scan and continuous-scan modes
module sc_mux_seq #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 22,
  parameter int SEL_W  = 5
) (
  input logic          clk,
  input logic          rst,
  sc_mux_seq_if.slave  bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  ptr, ptr_nxt;
  logic [1:0]        mode_q;
  logic              busy_nxt;
  logic              done_nxt;
  logic              ld;
  logic [SEL_W-1:0]  ld_ch;
  logic [DATA_W-1:0] word;
  logic              err_set;
  logic              ld_ok;
  logic              manual;
  logic              mode_chg;
  logic              sel_bad;
  logic              ptr_last;

  assign ld_ok    = !bus.hold && (!bus.out_vld || bus.out_ready);
  assign manual   = (bus.mode == 2'b00) || (bus.mode == 2'b11);
  assign mode_chg = (bus.mode != mode_q);
  assign sel_bad  = int'(bus.sel) >= N_CH;
  assign ptr_last = (ptr == SEL_W'(N_CH - 1));

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    busy_nxt  = bus.busy;
    done_nxt  = 1'b0;
    ld        = 1'b0;
    ld_ch     = ptr;
    err_set   = 1'b0;

    if (manual) begin
      if (sel_bad) begin
        err_set = 1'b1;
      end else if (ld_ok) begin
        ld    = 1'b1;
        ld_ch = bus.sel;
      end
    end

    // A mode switch aborts any scan in flight; the output register keeps its word.
    if (mode_chg) begin
      state_nxt = IDLE;
      ptr_nxt   = '0;
      busy_nxt  = 1'b0;
    end else if (bus.mode == 2'b01) begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.hold) begin
            state_nxt = SCAN;
            ptr_nxt   = '0;
            busy_nxt  = 1'b1;
          end
        end
        SCAN: begin
          if (ld_ok) begin
            ld = 1'b1;
            if (ptr_last) begin
              state_nxt = IDLE;
              ptr_nxt   = '0;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              ptr_nxt = ptr + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (bus.mode == 2'b10) begin
      if (ld_ok) begin
        ld      = 1'b1;
        ptr_nxt = ptr_last ? '0 : ptr + 1'b1;
      end
    end
  end

  always_comb begin
    word = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ld_ch == SEL_W'(k)) word = bus.in_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      mode_q       <= 2'b00;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.out_data <= '0;
      bus.out_ch   <= '0;
      bus.out_vld  <= 1'b0;
      bus.err_sel  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      mode_q   <= bus.mode;
      bus.busy <= busy_nxt;
      bus.done <= done_nxt;
      if (ld) begin
        bus.out_data <= word;
        bus.out_ch   <= ld_ch;
        bus.out_vld  <= 1'b1;
      end else if (bus.out_vld && bus.out_ready) begin
        bus.out_vld <= 1'b0;
      end
      if (err_set)          bus.err_sel <= 1'b1;
      else if (bus.err_clr) bus.err_sel <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sc_mux_seq.sv
// tb/tb_sc_mux_seq.sv - directed scoreboard bench for sc_mux_seq
module tb_sc_mux_seq;
  localparam int DATA_W = 8;
  localparam int N_CH   = 22;
  localparam int SEL_W  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sc_mux_seq_if #(.DATA_W(DATA_W), .N_CH(N_CH), .SEL_W(SEL_W)) bif ();

  sc_mux_seq #(.DATA_W(DATA_W), .N_CH(N_CH), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [SEL_W+DATA_W-1:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_ch(input int k);
    sb.push_back({SEL_W'(k), DATA_W'(8'hA0 + k)});
  endfunction

  // Handshake is judged at the negedge before the edge that completes it.
  task automatic cyc();
    logic [SEL_W+DATA_W-1:0] e;
    @(negedge clk);
    if (bif.out_vld && bif.out_ready) begin
      check("word_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_ch", 32'(bif.out_ch), 32'(e[SEL_W+DATA_W-1:DATA_W]));
        check("out_data", 32'(bif.out_data), 32'(e[DATA_W-1:0]));
      end
      check("tag_range", 32'(int'(bif.out_ch) < N_CH), 1);
    end
    @(posedge clk);
    #1;
    if (bif.done) done_cnt++;
  endtask

  initial begin
    int d0;
    for (int k = 0; k < N_CH; k++) bif.in_data[k*DATA_W +: DATA_W] = DATA_W'(8'hA0 + k);
    bif.mode = 2'b00; bif.sel = '0; bif.start = 0; bif.hold = 1;
    bif.out_ready = 1; bif.err_clr = 0;

    #12;
    check("rst_vld", 32'(bif.out_vld), 0);
    check("rst_data", 32'(bif.out_data), 0);
    check("rst_busy", 32'(bif.busy), 0);
    check("rst_err", 32'(bif.err_sel), 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // Manual select
    bif.hold = 0; bif.sel = 5; push_ch(5);
    cyc();
    check("man5_data", 32'(bif.out_data), 32'h A5);
    check("man5_ch", 32'(bif.out_ch), 5);
    check("man5_vld", 32'(bif.out_vld), 1);
    bif.sel = 21; push_ch(21);
    cyc();
    check("man21_data", 32'(bif.out_data), 32'h B5);

    // Illegal select
    bif.sel = 22;
    cyc();
    check("ill_err", 32'(bif.err_sel), 1);
    check("ill_vld", 32'(bif.out_vld), 0);
    bif.hold = 1; bif.sel = 0; bif.err_clr = 1;
    cyc();
    check("clr_err", 32'(bif.err_sel), 0);
    check("clr_vld", 32'(bif.out_vld), 0);
    bif.sel = 30;
    cyc();
    check("set_wins", 32'(bif.err_sel), 1);
    bif.err_clr = 0; bif.sel = 0;

    // Single scan with backpressure
    bif.mode = 2'b01; bif.hold = 0;
    cyc();
    bif.start = 1;
    cyc();
    bif.start = 0;
    check("scan_busy", 32'(bif.busy), 1);
    for (int k = 0; k < N_CH; k++) push_ch(k);
    d0 = done_cnt;
    for (int i = 0; i < 200 && sb.size() > 0; i++) begin
      bif.out_ready = i[0];
      cyc();
      if (bif.done) begin
        check("done_tag", 32'(bif.out_ch), 32'(N_CH - 1));
        check("done_busy", 32'(bif.busy), 0);
      end
    end
    bif.out_ready = 1;
    cyc();
    check("scan_drained", 32'(sb.size()), 0);
    check("scan_done_once", 32'(done_cnt - d0), 1);

    // Continuous scan and hold
    bif.mode = 2'b10;
    for (int k = 0; k < N_CH; k++) push_ch(k);
    for (int k = 0; k < 7; k++) push_ch(k);
    d0 = done_cnt;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (bif.out_vld && bif.out_ch == 6 && sb.size() == 1) break;
    end
    check("cont_at6", 32'(bif.out_ch), 6);
    bif.hold = 1;
    repeat (3) cyc();
    check("hold_vld", 32'(bif.out_vld), 0);
    check("hold_drained", 32'(sb.size()), 0);
    bif.hold = 0; push_ch(7);
    cyc();
    check("resume_ch", 32'(bif.out_ch), 7);
    bif.hold = 1;
    cyc();
    check("cont_no_done", 32'(done_cnt - d0), 0);

    // Mode abort
    bif.mode = 2'b01; bif.hold = 0;
    cyc();
    bif.start = 1;
    cyc();
    bif.start = 0;
    for (int k = 0; k < 10; k++) push_ch(k);
    d0 = done_cnt;
    repeat (10) cyc();
    check("abort_ch9", 32'(bif.out_ch), 9);
    bif.out_ready = 0; bif.mode = 2'b00;
    cyc();
    check("abort_busy", 32'(bif.busy), 0);
    check("abort_hold_ch", 32'(bif.out_ch), 9);
    check("abort_no_done", 32'(done_cnt - d0), 0);
    bif.mode = 2'b01;
    cyc();
    bif.start = 1;
    cyc();
    bif.start = 0; bif.out_ready = 1;
    for (int k = 0; k < N_CH; k++) push_ch(k);
    d0 = done_cnt;
    for (int i = 0; i < 100 && sb.size() > 0; i++) cyc();
    check("restart_drained", 32'(sb.size()), 0);
    check("restart_done", 32'(done_cnt - d0), 1);

    // Asynchronous reset with a word pending
    bif.out_ready = 0; bif.mode = 2'b00; bif.sel = 3;
    cyc(); cyc();
    check("pre_rst_vld", 32'(bif.out_vld), 1);
    @(negedge clk); #2; rst = 1; #1;
    check("arst_vld", 32'(bif.out_vld), 0);
    check("arst_data", 32'(bif.out_data), 0);
    check("arst_ch", 32'(bif.out_ch), 0);
    check("arst_err", 32'(bif.err_sel), 0);
    bif.hold = 1;
    #10; rst = 0;
    cyc(); cyc();
    check("post_rst_vld", 32'(bif.out_vld), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
